// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: time-of-day scheduler that shares one pump between
// NCH valve channels. Channels whose start time is reached are queued as
// pending and served one at a time in round-robin order. An emergency
// request pre-empts the pump for a fixed number of ticks. After that the
// interrupted channel resumes.
//
// Optional feature: define SCHED_MISS_CNT_EN to add the miss_cnt output.
// miss_cnt is a saturating count of arming matches dropped because the
// channel was already pending or being served.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick            time-base strobe, one clk wide
//   cfg_*           per-channel config write (start, dur, en)
//   emerg_req/dur   emergency request (rising edge) and its length in ticks
//   valve           one-hot valve drive
//   pump            pump drive
//   emerg_out       emergency running
//   busy            state is not IDLE
//   pend            pending flags
//   now             time of day
//   miss_cnt        dropped-match count (SCHED_MISS_CNT_EN only)
module irrigation_scheduler #(
   parameter int unsigned NCH = 4,
   parameter int unsigned TW  = 5,
   parameter int unsigned DW  = 5,
   localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          cfg_we,
   input  logic [CW-1:0] cfg_ch,
   input  logic [TW-1:0] cfg_start,
   input  logic [DW-1:0] cfg_dur,
   input  logic          cfg_en,
   input  logic          emerg_req,
   input  logic [DW-1:0] emerg_dur,
   output logic [NCH-1:0] valve,
   output logic          pump,
   output logic          emerg_out,
   output logic          busy,
   output logic [NCH-1:0] pend,
   output logic [TW-1:0] now
`ifdef SCHED_MISS_CNT_EN
   ,
   output logic [7:0]    miss_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, EMERG} state_t;

   state_t          state, state_n;
   logic [TW-1:0]   cfg_start_q [NCH];
   logic [DW-1:0]   cfg_dur_q   [NCH];
   logic [NCH-1:0]  cfg_en_q;
   logic [CW-1:0]   rr_last, rr_last_n;
   logic [CW-1:0]   ch, ch_n;
   logic [DW-1:0]   rem, rem_n;
   logic [DW-1:0]   ecnt, ecnt_n;
   logic            paused, paused_n;
   logic            emerg_q;

   logic [TW-1:0]   now_n;
   logic [NCH-1:0]  pend_n, valve_n;
   logic            emerg_out_n, busy_n, pump_n;

   logic [NCH-1:0]  cfg_hit, cfg_clr, arm, cand;
   logic [CW-1:0]   idx, sel;
   logic            found, serve_dis, emerg_go, hold;
`ifdef SCHED_MISS_CNT_EN
   logic [NCH-1:0]  drops;
   logic [7:0]      miss_n;
`endif

   function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] c);
      return NCH'(1) << c;
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      now_n       = now;
      pend_n      = pend;
      valve_n     = valve;
      emerg_out_n = emerg_out;
      rr_last_n   = rr_last;
      ch_n        = ch;
      rem_n       = rem;
      ecnt_n      = ecnt;
      paused_n    = paused;
      idx         = rr_last;
      sel         = rr_last;
      found       = 1'b0;
      hold        = 1'b0;
      cfg_hit     = '0;
      arm         = '0;
`ifdef SCHED_MISS_CNT_EN
      miss_n      = miss_cnt;
`endif

      for (int i = 0; i < NCH; i++) begin
         cfg_hit[i] = cfg_we && (cfg_ch == CW'(i));
      end
      cfg_clr   = cfg_en ? '0 : cfg_hit;
      serve_dis = cfg_we && !cfg_en && (cfg_ch == ch);
      emerg_go  = emerg_req && !emerg_q && (emerg_dur != '0);

      if (tick) now_n = now + TW'(1);

      // Arming; a config write to the same channel wins over its match
      for (int i = 0; i < NCH; i++) begin
         arm[i] = tick && cfg_en_q[i] && (cfg_start_q[i] == now) && !cfg_hit[i];
      end
      pend_n = pend | arm;
`ifdef SCHED_MISS_CNT_EN
      drops = arm & pend;
      for (int i = 0; i < NCH; i++) begin
         if (drops[i] && (miss_n != 8'hFF)) miss_n = miss_n + 8'd1;
      end
`endif

      // Round-robin search starting after rr_last
      cand = pend & ~cfg_clr;
      for (int k = 0; k < NCH; k++) begin
         idx = (idx == CW'(NCH - 1)) ? '0 : idx + CW'(1);
         if (!found && cand[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end

      case (state)
         IDLE: begin
            if (emerg_go) begin
               state_n     = EMERG;
               emerg_out_n = 1'b1;
               ecnt_n      = emerg_dur;
               valve_n     = '0;
               paused_n    = 1'b0;
            end else if (found) begin
               if (cfg_dur_q[sel] == '0) begin
                  pend_n    = pend_n & ~onehot(sel);
                  rr_last_n = sel;
               end else begin
                  valve_n = onehot(sel);
                  ch_n    = sel;
                  rem_n   = cfg_dur_q[sel];
                  state_n = RUN;
               end
            end
         end
         RUN: begin
            if (serve_dis) begin
               // Disabled while served: close without advancing rr_last
               valve_n = '0;
               state_n = IDLE;
            end else if (tick) begin
               if (rem == DW'(1)) begin
                  valve_n   = '0;
                  pend_n    = pend_n & ~onehot(ch);
                  rr_last_n = ch;
                  state_n   = IDLE;
               end else begin
                  rem_n = rem - DW'(1);
               end
            end
            // Expiry/disable complete first, then the emergency takes over
            if (emerg_go) begin
               paused_n    = (state_n == RUN);
               state_n     = EMERG;
               emerg_out_n = 1'b1;
               ecnt_n      = emerg_dur;
               valve_n     = '0;
            end
         end
         EMERG: begin
            hold     = paused && !serve_dis;
            paused_n = hold;
            if (tick) begin
               if (ecnt == DW'(1)) begin
                  emerg_out_n = 1'b0;
                  paused_n    = 1'b0;
                  if (hold) begin
                     valve_n = onehot(ch);
                     state_n = RUN;
                  end else begin
                     state_n = IDLE;
                  end
               end else begin
                  ecnt_n = ecnt - DW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase

      pend_n = pend_n & ~cfg_clr;
      busy_n = (state_n != IDLE);
      pump_n = (valve_n != '0) || emerg_out_n;
   end

   // State, datapath and config registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         now       <= '0;
         pend      <= '0;
         valve     <= '0;
         pump      <= 1'b0;
         emerg_out <= 1'b0;
         busy      <= 1'b0;
         rr_last   <= CW'(NCH - 1);
         ch        <= '0;
         rem       <= '0;
         ecnt      <= '0;
         paused    <= 1'b0;
         emerg_q   <= 1'b0;
         cfg_en_q  <= '0;
         for (int i = 0; i < NCH; i++) begin
            cfg_start_q[i] <= '0;
            cfg_dur_q[i]   <= '0;
         end
`ifdef SCHED_MISS_CNT_EN
         miss_cnt  <= '0;
`endif
      end else begin
         state     <= state_n;
         now       <= now_n;
         pend      <= pend_n;
         valve     <= valve_n;
         pump      <= pump_n;
         emerg_out <= emerg_out_n;
         busy      <= busy_n;
         rr_last   <= rr_last_n;
         ch        <= ch_n;
         rem       <= rem_n;
         ecnt      <= ecnt_n;
         paused    <= paused_n;
         emerg_q   <= emerg_req;
         if (cfg_we) begin
            cfg_start_q[cfg_ch] <= cfg_start;
            cfg_dur_q[cfg_ch]   <= cfg_dur;
            cfg_en_q[cfg_ch]    <= cfg_en;
         end
`ifdef SCHED_MISS_CNT_EN
         miss_cnt  <= miss_n;
`endif
      end
   end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed self-checking bench for irrigation_scheduler (NCH=4, TW=5, DW=5).
module tb_irrigation_scheduler;

   logic       clk = 1'b0;
   logic       rst, tick, cfg_we, cfg_en, emerg_req;
   logic [1:0] cfg_ch;
   logic [4:0] cfg_start, cfg_dur, emerg_dur;
   logic [3:0] valve, pend;
   logic       pump, emerg_out, busy;
   logic [4:0] now;
`ifdef SCHED_MISS_CNT_EN
   logic [7:0] miss_cnt;
`endif

   int checks = 0;
   int errors = 0;
   logic [4:0] exp_now;

   irrigation_scheduler dut (
      .clk(clk), .rst(rst), .tick(tick),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_start(cfg_start),
      .cfg_dur(cfg_dur), .cfg_en(cfg_en),
      .emerg_req(emerg_req), .emerg_dur(emerg_dur),
      .valve(valve), .pump(pump), .emerg_out(emerg_out), .busy(busy),
      .pend(pend), .now(now)
`ifdef SCHED_MISS_CNT_EN
      , .miss_cnt(miss_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, tick, we;
      logic [1:0] ch;
      logic [4:0] st, du;
      logic       en, er;
      logic [4:0] ed;
      logic [3:0] v;
      logic       p, e, b;
      logic [3:0] pd;
      logic [4:0] nw;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic r, t, w, input logic [1:0] c,
                               input logic [4:0] s, d, input logic n, er,
                               input logic [4:0] ed, input logic [3:0] v,
                               input logic p, e, b, input logic [3:0] pd,
                               input logic [4:0] nw);
      vec_t x;
      x.rst = r; x.tick = t; x.we = w; x.ch = c; x.st = s; x.du = d;
      x.en = n; x.er = er; x.ed = ed; x.v = v; x.p = p; x.e = e; x.b = b;
      x.pd = pd; x.nw = nw;
      return x;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] ev, input logic ep,
                      input logic ee, input logic eb, input logic [3:0] epd,
                      input logic [4:0] enw);
      checks++;
      if ({valve, pump, emerg_out, busy, pend, now} !== {ev, ep, ee, eb, epd, enw}) begin
         errors++;
         $display("FAIL %s: got valve=%b pump=%b emerg=%b busy=%b pend=%b now=%0d, want valve=%b pump=%b emerg=%b busy=%b pend=%b now=%0d",
                  nm, valve, pump, emerg_out, busy, pend, now, ev, ep, ee, eb, epd, enw);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; emerg_req = 1'b0;
      step();
      rst = 1'b0;
      exp_now = '0;
   endtask

   task automatic cfg(input logic [1:0] c, input logic [4:0] s, input logic [4:0] d, input logic n);
      tick = 1'b0; cfg_we = 1'b1; cfg_ch = c; cfg_start = s; cfg_dur = d; cfg_en = n;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic cyc(input logic t, input logic er, input logic [4:0] ed);
      tick = t; emerg_req = er; emerg_dur = ed; cfg_we = 1'b0;
      step();
      if (t) exp_now = exp_now + 5'd1;
      tick = 1'b0;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_start = '0;
      cfg_dur = '0; cfg_en = 1'b0; emerg_req = 1'b0; emerg_dur = '0;
      exp_now = '0;

      // Ch0 start=2 dur=3, then idle emergency handling
      tbl[0]  = mk(1,0,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,0);
      tbl[1]  = mk(0,0,1,0,2,3,1,0,0, 4'b0000,0,0,0,4'b0000,0);
      tbl[2]  = mk(0,1,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,1);
      tbl[3]  = mk(0,0,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,1);
      tbl[4]  = mk(0,1,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,2);
      tbl[5]  = mk(0,0,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,2);
      tbl[6]  = mk(0,1,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0001,3);
      tbl[7]  = mk(0,0,0,0,0,0,0,0,0, 4'b0001,1,0,1,4'b0001,3);
      tbl[8]  = mk(0,1,0,0,0,0,0,0,0, 4'b0001,1,0,1,4'b0001,4);
      tbl[9]  = mk(0,0,0,0,0,0,0,0,0, 4'b0001,1,0,1,4'b0001,4);
      tbl[10] = mk(0,1,0,0,0,0,0,0,0, 4'b0001,1,0,1,4'b0001,5);
      tbl[11] = mk(0,0,0,0,0,0,0,0,0, 4'b0001,1,0,1,4'b0001,5);
      tbl[12] = mk(0,1,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,6);
      tbl[13] = mk(0,0,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,6);
      tbl[14] = mk(0,0,0,0,0,0,0,1,0, 4'b0000,0,0,0,4'b0000,6);
      tbl[15] = mk(0,0,0,0,0,0,0,0,0, 4'b0000,0,0,0,4'b0000,6);
      tbl[16] = mk(0,0,0,0,0,0,0,1,2, 4'b0000,1,1,1,4'b0000,6);
      tbl[17] = mk(0,1,0,0,0,0,0,1,2, 4'b0000,1,1,1,4'b0000,7);
      tbl[18] = mk(0,1,0,0,0,0,0,0,2, 4'b0000,0,0,0,4'b0000,8);

      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst; tick = tbl[i].tick; cfg_we = tbl[i].we;
         cfg_ch = tbl[i].ch; cfg_start = tbl[i].st; cfg_dur = tbl[i].du;
         cfg_en = tbl[i].en; emerg_req = tbl[i].er; emerg_dur = tbl[i].ed;
         step();
         chk($sformatf("row%0d", i), tbl[i].v, tbl[i].p, tbl[i].e, tbl[i].b, tbl[i].pd, tbl[i].nw);
      end

      // Round robin: ch1 and ch2 both start at 5, two days in a row
      do_reset();
      cfg(1, 5, 2, 1);
      cfg(2, 5, 2, 1);
      repeat (5) cyc(1, 0, 0);
      cyc(1, 0, 0); chk("rr_arm",    4'b0000, 0, 0, 0, 4'b0110, exp_now);
      cyc(0, 0, 0); chk("rr_ch1",    4'b0010, 1, 0, 1, 4'b0110, exp_now);
      cyc(1, 0, 0); cyc(1, 0, 0);
                    chk("rr_ch1end", 4'b0000, 0, 0, 0, 4'b0100, exp_now);
      cyc(0, 0, 0); chk("rr_ch2",    4'b0100, 1, 0, 1, 4'b0100, exp_now);
      cyc(1, 0, 0); cyc(1, 0, 0);
                    chk("rr_ch2end", 4'b0000, 0, 0, 0, 4'b0000, exp_now);
      for (int i = 0; i < 27; i++) cyc(1, 0, 0);
      cyc(1, 0, 0); chk("rr2_arm",   4'b0000, 0, 0, 0, 4'b0110, exp_now);
      cyc(0, 0, 0); chk("rr2_ch1",   4'b0010, 1, 0, 1, 4'b0110, exp_now);
      cyc(1, 0, 0); cyc(1, 0, 0);
      cyc(0, 0, 0); chk("rr2_ch2",   4'b0100, 1, 0, 1, 4'b0100, exp_now);

      // Emergency pre-empts ch0 with rem=3, then ch0 resumes
      do_reset();
      cfg(0, 0, 5, 1);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0); cyc(1, 0, 0);
                    chk("em_run",    4'b0001, 1, 0, 1, 4'b0001, exp_now);
      cyc(0, 1, 2); chk("em_enter",  4'b0000, 1, 1, 1, 4'b0001, exp_now);
      cyc(1, 1, 2); chk("em_mid",    4'b0000, 1, 1, 1, 4'b0001, exp_now);
      cyc(0, 0, 2); cyc(0, 1, 2);
                    chk("em_reedge", 4'b0000, 1, 1, 1, 4'b0001, exp_now);
      cyc(1, 1, 2); chk("em_resume", 4'b0001, 1, 0, 1, 4'b0001, exp_now);
      cyc(1, 0, 0); cyc(1, 0, 0);
                    chk("em_rem",    4'b0001, 1, 0, 1, 4'b0001, exp_now);
      cyc(1, 0, 0); chk("em_done",   4'b0000, 0, 0, 0, 4'b0000, exp_now);

      // Emergency edge on the same edge as the run expiry tick
      do_reset();
      cfg(0, 0, 2, 1);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
      cyc(1, 1, 3); chk("sim_enter", 4'b0000, 1, 1, 1, 4'b0000, exp_now);
      cyc(1, 1, 3); cyc(1, 1, 3);
                    chk("sim_mid",   4'b0000, 1, 1, 1, 4'b0000, exp_now);
      cyc(1, 0, 3); chk("sim_exit",  4'b0000, 0, 0, 0, 4'b0000, exp_now);

      // Zero-duration channel is consumed without opening its valve
      do_reset();
      cfg(3, 1, 0, 1);
      cyc(1, 0, 0); cyc(1, 0, 0);
                    chk("d0_arm",    4'b0000, 0, 0, 0, 4'b1000, exp_now);
      cyc(0, 0, 0); chk("d0_clear",  4'b0000, 0, 0, 0, 4'b0000, exp_now);

      // Disabling the served channel closes it at once
      do_reset();
      cfg(0, 0, 5, 1);
      cyc(1, 0, 0); cyc(0, 0, 0);
                    chk("dis_run",   4'b0001, 1, 0, 1, 4'b0001, exp_now);
      cfg(0, 0, 5, 0);
                    chk("dis_off",   4'b0000, 0, 0, 0, 4'b0000, exp_now);

      // Reset mid-run
      do_reset();
      cfg(1, 0, 4, 1);
      cyc(1, 0, 0); cyc(0, 0, 0); cyc(1, 0, 0);
                    chk("rst_run",   4'b0010, 1, 0, 1, 4'b0010, exp_now);
      do_reset();   chk("rst_mid",   4'b0000, 0, 0, 0, 4'b0000, 5'd0);

      // Full-length run across the time wrap; rematch is dropped
      do_reset();
      cfg(0, 0, 31, 1);
      for (int i = 0; i < 32; i++) cyc(1, 0, 0);
                    chk("wrap_run",  4'b0001, 1, 0, 1, 4'b0001, exp_now);
      cyc(1, 0, 0); chk("wrap_end",  4'b0000, 0, 0, 0, 4'b0000, exp_now);
`ifdef SCHED_MISS_CNT_EN
      checks++;
      if (miss_cnt !== 8'd1) begin
         errors++;
         $display("FAIL miss_cnt: got %0d, want 1", miss_cnt);
      end
      do_reset();
      checks++;
      if (miss_cnt !== 8'd0) begin
         errors++;
         $display("FAIL miss_rst: got %0d, want 0", miss_cnt);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
